// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the packed-BCD counter family.
package bcd_pkg;

    localparam int BCD_DW  = 4;
    localparam int MAX_DIG = 8;

    // True when the low ndig nibbles of v are all decimal digits.
    function automatic logic is_bcd(input logic [31:0] v, input int ndig);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < MAX_DIG; i++) begin
            if (i < ndig && v[BCD_DW*i +: BCD_DW] > 4'd9)
                ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [31:0] bcd_const(input int val);
        logic [31:0] res;
        int          r;
        res = '0;
        r   = val;
        for (int i = 0; i < MAX_DIG; i++) begin
            res[BCD_DW*i +: BCD_DW] = 4'(r % 10);
            r = r / 10;
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the up/down ripple chain; ci is carry-in (up) or borrow-in (down).
module bcd_digit
    import bcd_pkg::*;
(
    input  logic [BCD_DW-1:0] d,
    input  logic              up,
    input  logic              ci,
    output logic [BCD_DW-1:0] q,
    output logic              co
);

    always_comb begin
        q  = d;
        co = 1'b0;
        if (ci) begin
            if (up) begin
                if (d == 4'd9) begin
                    q  = 4'd0;
                    co = 1'b1;
                end else begin
                    q  = d + 4'd1;
                end
            end else begin
                if (d == 4'd0) begin
                    q  = 4'd9;
                    co = 1'b1;
                end else begin
                    q  = d - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_updown_cntr.sv
// N-digit packed-BCD up/down counter over MINVAL..MAXVAL with clear, checked load and wrap pulses.
module bcd_updown_cntr
    import bcd_pkg::*;
#(
    parameter int                       NDIG   = 2,
    parameter logic [BCD_DW*NDIG-1:0]   MINVAL = '0,
    parameter logic [BCD_DW*NDIG-1:0]   MAXVAL = (BCD_DW*NDIG)'(bcd_const((NDIG == 1) ? 9 : 59)),
    parameter logic [BCD_DW*NDIG-1:0]   RSTVAL = MINVAL
) (
    input  logic                      CLK1K,
    input  logic                      RSTN,
    input  logic                      EN,
    input  logic                      UP,
    input  logic                      CLR,
    input  logic                      LOAD,
    input  logic [BCD_DW*NDIG-1:0]    LOAD_VAL,
    output logic [BCD_DW*NDIG-1:0]    BCD,
    output logic                      CARRY,
    output logic                      BORROW,
    output logic                      LOAD_ERR,
    output logic                      AT_MAX,
    output logic                      AT_MIN
);

    localparam logic P_OK = (NDIG >= 1) && (NDIG <= MAX_DIG)
                         && is_bcd(32'(MINVAL), NDIG) && is_bcd(32'(MAXVAL), NDIG)
                         && is_bcd(32'(RSTVAL), NDIG) && (MINVAL < MAXVAL)
                         && (MINVAL <= RSTVAL) && (RSTVAL <= MAXVAL);

    generate
        if (!P_OK) begin : g_bad_param
            $error("bcd_updown_cntr: illegal NDIG/MINVAL/MAXVAL/RSTVAL");
        end
    endgenerate

    logic [BCD_DW*NDIG-1:0] r_bcd;
    logic                   r_carry;
    logic                   r_borrow;
    logic                   r_lerr;

    logic [BCD_DW*NDIG-1:0] w_step;
    logic [NDIG:0]          w_ci;
    logic                   w_unused_co;
    logic                   w_ge_min;
    logic                   w_load_ok;
    logic                   w_at_max;
    logic                   w_at_min;

    assign w_ci[0]     = EN;
    assign w_unused_co = w_ci[NDIG];

    genvar g;
    generate
        for (g = 0; g < NDIG; g++) begin : g_dig
            bcd_digit u_dig (
                .d  (r_bcd[BCD_DW*g +: BCD_DW]),
                .up (UP),
                .ci (w_ci[g]),
                .q  (w_step[BCD_DW*g +: BCD_DW]),
                .co (w_ci[g+1])
            );
        end

        // A zero floor makes the lower-bound compare constant, so skip it.
        if (MINVAL == '0) begin : g_min0
            assign w_ge_min = 1'b1;
        end else begin : g_minx
            assign w_ge_min = (LOAD_VAL >= MINVAL);
        end
    endgenerate

    assign w_load_ok = is_bcd(32'(LOAD_VAL), NDIG) && w_ge_min && (LOAD_VAL <= MAXVAL);
    assign w_at_max  = (r_bcd == MAXVAL);
    assign w_at_min  = (r_bcd == MINVAL);

    always_ff @(posedge CLK1K or negedge RSTN) begin
        if (!RSTN) begin
            r_bcd    <= RSTVAL;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
            r_lerr   <= 1'b0;
        end else begin
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
            r_lerr   <= 1'b0;
            if (CLR) begin
                r_bcd <= MINVAL;
            end else if (LOAD) begin
                if (w_load_ok)
                    r_bcd  <= LOAD_VAL;
                else
                    r_lerr <= 1'b1;
            end else if (EN) begin
                // Range wrap overrides whatever the ripple chain produced.
                if (UP) begin
                    if (w_at_max) begin
                        r_bcd   <= MINVAL;
                        r_carry <= 1'b1;
                    end else begin
                        r_bcd   <= w_step;
                    end
                end else begin
                    if (w_at_min) begin
                        r_bcd    <= MAXVAL;
                        r_borrow <= 1'b1;
                    end else begin
                        r_bcd    <= w_step;
                    end
                end
            end
        end
    end

    assign BCD      = r_bcd;
    assign CARRY    = r_carry;
    assign BORROW   = r_borrow;
    assign LOAD_ERR = r_lerr;
    assign AT_MAX   = w_at_max;
    assign AT_MIN   = w_at_min;

endmodule

// File: tb/tb_bcd_updown_cntr.sv
// Bench: table vectors and random traffic on a 00..59 counter, plus 3-digit and reset corner cases.
module tb_bcd_updown_cntr;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // u0: defaults, 00..59
    logic       rst0_n, en0, up0, clr0, ld0;
    logic [7:0] lv0, bcd0;
    logic       c0, b0, e0, amax0, amin0;
    // u1: 3 digits, 001..999
    logic        rst1_n, en1, up1, clr1, ld1;
    logic [11:0] lv1, bcd1;
    logic        c1, b1, e1, amax1, amin1;
    // u2: 00..59 with reset value 30
    logic       rst2_n, en2, up2, clr2, ld2;
    logic [7:0] lv2, bcd2;
    logic       c2, b2, e2, amax2, amin2;

    bcd_updown_cntr u0 (
        .CLK1K(clk), .RSTN(rst0_n), .EN(en0), .UP(up0), .CLR(clr0), .LOAD(ld0),
        .LOAD_VAL(lv0), .BCD(bcd0), .CARRY(c0), .BORROW(b0), .LOAD_ERR(e0),
        .AT_MAX(amax0), .AT_MIN(amin0));

    bcd_updown_cntr #(.NDIG(3), .MINVAL(12'h001), .MAXVAL(12'h999), .RSTVAL(12'h001)) u1 (
        .CLK1K(clk), .RSTN(rst1_n), .EN(en1), .UP(up1), .CLR(clr1), .LOAD(ld1),
        .LOAD_VAL(lv1), .BCD(bcd1), .CARRY(c1), .BORROW(b1), .LOAD_ERR(e1),
        .AT_MAX(amax1), .AT_MIN(amin1));

    bcd_updown_cntr #(.NDIG(2), .RSTVAL(8'h30)) u2 (
        .CLK1K(clk), .RSTN(rst2_n), .EN(en2), .UP(up2), .CLR(clr2), .LOAD(ld2),
        .LOAD_VAL(lv2), .BCD(bcd2), .CARRY(c2), .BORROW(b2), .LOAD_ERR(e2),
        .AT_MAX(amax2), .AT_MIN(amin2));

    typedef struct {
        logic       clr, ld, en, up;
        logic [7:0] lv;
        logic [7:0] bcd;
        logic       c, b, e;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic clr, ld, en, up, input logic [7:0] lv,
                                input logic [7:0] bcd, input logic c, b, e);
        vec_t v;
        v.clr = clr; v.ld = ld; v.en = en; v.up = up; v.lv = lv;
        v.bcd = bcd; v.c = c; v.b = b; v.e = e;
        return v;
    endfunction

    function automatic int b2i(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] i2b(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic lv_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (b2i(v) <= 59);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Every cycle u0 must hold a legal BCD value inside 00..59.
    always @(negedge clk) begin
        if (rst0_n === 1'b1) begin
            total++;
            if (!lv_ok(bcd0)) begin
                bad++;
                $display("FAIL u0_range: got %h want 00..59 BCD", bcd0);
            end
        end
    end

    task automatic chk_u0(input string name, input logic [7:0] eb, input logic ec, ebr, ee);
        chk({name, ".bcd"},    32'(bcd0),  32'(eb));
        chk({name, ".carry"},  32'(c0),    32'(ec));
        chk({name, ".borrow"}, 32'(b0),    32'(ebr));
        chk({name, ".lerr"},   32'(e0),    32'(ee));
        chk({name, ".atmax"},  32'(amax0), 32'(eb == 8'h59));
        chk({name, ".atmin"},  32'(amin0), 32'(eb == 8'h00));
    endtask

    task automatic step_u0(input logic clr, ld, en, up, input logic [7:0] lv);
        clr0 = clr; ld0 = ld; en0 = en; up0 = up; lv0 = lv;
        @(posedge clk);
        #1;
    endtask

    task automatic step_u1(input logic ld, en, up, input logic [11:0] lv);
        ld1 = ld; en1 = en; up1 = up; lv1 = lv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         m;
        logic       rc, rl, re, ru, ec, eb, ee;
        logic [7:0] rv;

        rst0_n = 0; en0 = 0; up0 = 0; clr0 = 0; ld0 = 0; lv0 = '0;
        rst1_n = 0; en1 = 0; up1 = 0; clr1 = 0; ld1 = 0; lv1 = '0;
        rst2_n = 0; en2 = 0; up2 = 0; clr2 = 0; ld2 = 0; lv2 = '0;
        #12;
        chk_u0("reset0", 8'h00, 0, 0, 0);
        chk("reset1.bcd", 32'(bcd1), 32'h001);
        chk("reset2.bcd", 32'(bcd2), 32'h30);
        rst0_n = 1; rst1_n = 1; rst2_n = 1;

        //          clr ld en up  lv     bcd    c  b  e
        vt.push_back(mk(0, 1, 0, 0, 8'h58, 8'h58, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 1, 8'h00, 8'h59, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 1, 8'h00, 8'h00, 1, 0, 0));
        vt.push_back(mk(0, 0, 1, 1, 8'h00, 8'h01, 0, 0, 0));
        vt.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 0, 8'h00, 8'h59, 0, 1, 0));
        vt.push_back(mk(0, 0, 1, 0, 8'h00, 8'h58, 0, 0, 0));
        vt.push_back(mk(0, 1, 0, 0, 8'h10, 8'h10, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 0, 8'h00, 8'h09, 0, 0, 0));
        vt.push_back(mk(0, 1, 0, 0, 8'h23, 8'h23, 0, 0, 0));
        vt.push_back(mk(0, 1, 0, 0, 8'h3A, 8'h23, 0, 0, 1));
        vt.push_back(mk(0, 0, 0, 0, 8'h3A, 8'h23, 0, 0, 0));
        vt.push_back(mk(0, 1, 0, 0, 8'h60, 8'h23, 0, 0, 1));
        vt.push_back(mk(0, 1, 0, 0, 8'h47, 8'h47, 0, 0, 0));
        vt.push_back(mk(1, 1, 1, 1, 8'h30, 8'h00, 0, 0, 0));
        vt.push_back(mk(0, 1, 1, 1, 8'h30, 8'h30, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 1, 8'h00, 8'h30, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 1, 8'h00, 8'h31, 0, 0, 0));

        foreach (vt[i]) begin
            step_u0(vt[i].clr, vt[i].ld, vt[i].en, vt[i].up, vt[i].lv);
            chk_u0($sformatf("vec%0d", i), vt[i].bcd, vt[i].c, vt[i].b, vt[i].e);
        end

        // Random traffic against an integer model of the 0..59 range.
        m = b2i(vt[vt.size()-1].bcd);
        for (int n = 0; n < 400; n++) begin
            rc = ($urandom_range(15) == 0);
            rl = ($urandom_range(3) == 0);
            re = 1'($urandom_range(1));
            ru = 1'($urandom_range(1));
            rv = ($urandom_range(1) == 1) ? 8'($urandom) : i2b($urandom_range(59));
            ec = 0; eb = 0; ee = 0;
            if (rc) begin
                m = 0;
            end else if (rl) begin
                if (lv_ok(rv)) m = b2i(rv);
                else           ee = 1;
            end else if (re) begin
                if (ru) begin
                    if (m == 59) begin m = 0;  ec = 1; end
                    else         m = m + 1;
                end else begin
                    if (m == 0)  begin m = 59; eb = 1; end
                    else         m = m - 1;
                end
            end
            step_u0(rc, rl, re, ru, rv);
            chk_u0($sformatf("rnd%0d", n), i2b(m), ec, eb, ee);
        end
        step_u0(0, 0, 0, 0, 8'h00);

        // Three-digit ripple and wrap at custom bounds.
        step_u1(1, 0, 0, 12'h099);
        step_u1(0, 1, 1, 12'h000);
        chk("u1_ripple.bcd", 32'(bcd1), 32'h100);
        step_u1(0, 1, 0, 12'h000);
        chk("u1_down.bcd", 32'(bcd1), 32'h099);
        step_u1(1, 0, 0, 12'h999);
        chk("u1_atmax", 32'(amax1), 32'h1);
        step_u1(0, 1, 1, 12'h000);
        chk("u1_upwrap.bcd", 32'(bcd1), 32'h001);
        chk("u1_upwrap.carry", 32'(c1), 32'h1);
        chk("u1_atmin", 32'(amin1), 32'h1);
        step_u1(0, 1, 0, 12'h000);
        chk("u1_dnwrap.bcd", 32'(bcd1), 32'h999);
        chk("u1_dnwrap.borrow", 32'(b1), 32'h1);
        chk("u1_dnwrap.carry", 32'(c1), 32'h0);
        step_u1(0, 1, 0, 12'h000);
        chk("u1_dn2.bcd", 32'(bcd1), 32'h998);
        chk("u1_dn2.borrow", 32'(b1), 32'h0);
        step_u1(1, 0, 0, 12'h000);
        chk("u1_ldzero.lerr", 32'(e1), 32'h1);
        chk("u1_ldzero.bcd", 32'(bcd1), 32'h998);

        // Asynchronous reset between edges while a carry pulse is live.
        ld2 = 1; lv2 = 8'h59;
        @(posedge clk); #1;
        ld2 = 0; en2 = 1; up2 = 1;
        @(posedge clk); #1;
        chk("u2_wrap.bcd", 32'(bcd2), 32'h00);
        chk("u2_wrap.carry", 32'(c2), 32'h1);
        #3 rst2_n = 0;
        #1;
        chk("u2_async.bcd", 32'(bcd2), 32'h30);
        chk("u2_async.carry", 32'(c2), 32'h0);
        @(posedge clk); #1;
        chk("u2_held.bcd", 32'(bcd2), 32'h30);
        rst2_n = 1;
        @(posedge clk); #1;
        chk("u2_resume.bcd", 32'(bcd2), 32'h31);
        chk("u2_resume.carry", 32'(c2), 32'h0);
        en2 = 0;
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
